ex_mem_pipe_reg: RTL and testbench

//  Parametrised EX->MEM pipeline register for the MIPS core. Carries control bits, branch target,
//  ALU result, store data, destination register and ALU zero flag, with a valid/ready handshake,
//  a one-entry skid buffer for full throughput under back-pressure, and a synchronous flush.

---
 rtl/ex_mem_pipe_reg.sv | 152 +++++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register for the MIPS core.
// Carries control bits, branch target, ALU result, store data, destination
// register and ALU zero flag across a valid/ready handshake. A one-entry skid
// buffer keeps full throughput under back-pressure, so in_ready never has a
// combinational path from out_ready. A synchronous flush kills every held beat
// and the beat arriving in the same cycle.
//
// Optional feature: define EX_MEM_STALL_CNT_EN to add the stall_cnt port, a
// saturating count of cycles spent with out_valid=1 and out_ready=0.
module ex_mem_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 5,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_target,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_target,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_wdata,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_zero
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    // One pipeline beat as it travels from EX to MEM.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] target;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic [REG_W-1:0]  rd;
        logic              zero;
    } beat_t;

    // EMPTY: nothing held; FULL: main entry only; SKID: main and skid entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    // Reject degenerate widths at elaboration.
    if (DATA_W < 1 || CTRL_W < 1 || REG_W < 1 || CNT_W < 1) begin : g_param_chk
        $error("ex_mem_pipe_reg: all widths must be at least 1");
    end

    state_t state;
    beat_t  main_q;
    beat_t  skid_q;
    beat_t  in_beat;
    logic   accept;
    logic   send;

    // Pack the incoming EX fields into one beat.
    assign in_beat = {in_ctrl, in_target, in_alu, in_wdata, in_rd, in_zero};

    // Handshake qualifiers; both operands are flops or primary inputs.
    assign accept = in_valid && in_ready;
    assign send   = out_valid && out_ready;

    // Main entry drives the outputs directly; its ctrl field is zeroed
    // whenever it stops holding a live beat so bubbles carry no control.
    assign out_ctrl   = main_q.ctrl;
    assign out_target = main_q.target;
    assign out_alu    = main_q.alu;
    assign out_wdata  = main_q.wdata;
    assign out_rd     = main_q.rd;
    assign out_zero   = main_q.zero;

    // Occupancy FSM with registered out_valid and in_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            // Drop everything, keep data fields of main for observability.
            state       <= ST_EMPTY;
            main_q.ctrl <= '0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q    <= in_beat;
                        out_valid <= 1'b1;
                        state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && send) begin
                        main_q <= in_beat;
                    end else if (accept) begin
                        skid_q   <= in_beat;
                        in_ready <= 1'b0;
                        state    <= ST_SKID;
                    end else if (send) begin
                        main_q.ctrl <= '0;
                        out_valid   <= 1'b0;
                        state       <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (send) begin
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        state    <= ST_FULL;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    main_q.ctrl <= '0;
                    out_valid   <= 1'b0;
                    in_ready    <= 1'b1;
                end
            endcase
        end
    end

`ifdef EX_MEM_STALL_CNT_EN
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    // Saturating back-pressure counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Testbench for ex_mem_pipe_reg: directed scenarios followed by random traffic,
// checked by a queue-based scoreboard. Define EX_MEM_STALL_CNT_EN to also
// check the stall counter (built here with a 4-bit counter to reach saturation).
module tb_ex_mem_pipe_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 5;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] target;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic [REG_W-1:0]  rd;
        logic              zero;
    } beat_t;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_target;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_wdata;
    logic [REG_W-1:0]  out_rd;
    logic              out_zero;
`ifdef EX_MEM_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    beat_t drv;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    beat_t last_shown;
    logic  exp_ready;
    logic  started;
    int    stall_exp;

    ex_mem_pipe_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .REG_W (REG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (drv.ctrl),
        .in_target (drv.target),
        .in_alu    (drv.alu),
        .in_wdata  (drv.wdata),
        .in_rd     (drv.rd),
        .in_zero   (drv.zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_target(out_target),
        .out_alu   (out_alu),
        .out_wdata (out_wdata),
        .out_rd    (out_rd),
        .out_zero  (out_zero)
`ifdef EX_MEM_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.ctrl   = CTRL_W'($urandom);
        b.target = $urandom;
        b.alu    = $urandom;
        b.wdata  = $urandom;
        b.rd     = REG_W'($urandom);
        b.zero   = 1'($urandom);
        return b;
    endfunction

    // Stimulus side: record every beat the register is expected to accept.
    always @(posedge clk) begin
        if (started && !reset && !flush && in_valid && exp_ready)
            exp_q.push_back(drv);
    end

    // Monitor: compare presented outputs with the expected-beat queue.
    always @(negedge clk) begin
        int held;
        held = exp_q.size();
        if (started) begin
            chk("out_valid", 64'(out_valid), 64'(held != 0));
            chk("in_ready", 64'(in_ready), 64'(held < 2));
            if (held != 0) begin
                chk("out_ctrl", 64'(out_ctrl), 64'(exp_q[0].ctrl));
                chk("out_target", 64'(out_target), 64'(exp_q[0].target));
                chk("out_alu", 64'(out_alu), 64'(exp_q[0].alu));
                chk("out_wdata", 64'(out_wdata), 64'(exp_q[0].wdata));
                chk("out_rd", 64'(out_rd), 64'(exp_q[0].rd));
                chk("out_zero", 64'(out_zero), 64'(exp_q[0].zero));
                last_shown = exp_q[0];
            end else begin
                chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
                chk("hold_target", 64'(out_target), 64'(last_shown.target));
                chk("hold_alu", 64'(out_alu), 64'(last_shown.alu));
                chk("hold_wdata", 64'(out_wdata), 64'(last_shown.wdata));
                chk("hold_rd", 64'(out_rd), 64'(last_shown.rd));
                chk("hold_zero", 64'(out_zero), 64'(last_shown.zero));
            end
`ifdef EX_MEM_STALL_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
`endif
        end
        exp_ready = (held < 2);
        if (reset) begin
            exp_q.delete();
            last_shown = '0;
            stall_exp  = 0;
            started    = 1'b1;
        end else begin
            if (held != 0 && !out_ready && stall_exp < (1 << CNT_W) - 1)
                stall_exp++;
            if (flush)
                exp_q.delete();
            else if (held != 0 && out_ready)
                void'(exp_q.pop_front());
        end
    end

    task automatic step(input logic v, input beat_t b, input logic ordy,
                        input logic fl, input logic rst);
        in_valid  = v;
        drv       = b;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        beat_t b;
        beat_t idle;
        started    = 1'b0;
        exp_ready  = 1'b1;
        stall_exp  = 0;
        last_shown = '0;
        idle       = '0;
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        drv        = '0;
        repeat (3) @(posedge clk);
        #1;

        // Four back-to-back beats with MEM always ready.
        for (int i = 0; i < 4; i++) begin
            b     = rand_beat();
            b.alu = DATA_W'((i + 1) * 16);
            step(1'b1, b, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Back-pressure into the skid entry, then drain in order.
        b = rand_beat(); b.rd = 5'd5;
        step(1'b1, b, 1'b0, 1'b0, 1'b0);
        b = rand_beat(); b.rd = 5'd7;
        step(1'b1, b, 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Flush while in SKID with a new beat offered.
        step(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_beat(), 1'b0, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Reset and flush together with a beat offered: reset wins.
        step(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_beat(), 1'b1, 1'b1, 1'b1);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Bubble after a consumed beat keeps the data, zeroes ctrl.
        b = rand_beat(); b.ctrl = 5'b10101; b.alu = 32'h0000_0abc;
        step(1'b1, b, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Long stall to saturate the counter, then a flush.
        step(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b0, idle, 1'b0, 1'b0, 1'b0);
        step(1'b0, idle, 1'b0, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_beat(),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 199) == 0));
        end
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
